// File: rtl/line_buffer_interleave_pkg.sv
// Shared defaults and encodings for the ping-pong ADC line buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default sample width / row length (taken from the ADC width and
// row length defines when present), address-width helper, read FSM states.
`ifndef ADC_SAMPLE_W
`define ADC_SAMPLE_W 14
`endif
`ifndef ADC_ROW_PIXELS
`define ADC_ROW_PIXELS 640
`endif

package line_buffer_interleave_pkg;

    localparam int LBI_DATA_W      = `ADC_SAMPLE_W;
    localparam int LBI_PIX_PER_ROW = `ADC_ROW_PIXELS;

    // Address width for a memory of 'depth' entries; never narrower than 1 bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int LBI_ADDR_W = addr_w(LBI_PIX_PER_ROW);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_ARMED   = 2'd1,
        RD_READ    = 2'd2,
        RD_RELEASE = 2'd3
    } rd_state_t;

endpackage

// File: rtl/line_buffer_interleave_cdc_toggle_sync.sv
// Toggle synchroniser: carries an event across clock domains as a level toggle.
// Latency: pulse asserts SYNC_STAGES dst clocks after the toggle; consumer registers it one clock later.
// Backpressure: none; source must not toggle faster than the destination can observe.
// Ports: clk (destination clock), RESET (async, active-high), tgl (source-domain
// toggle level), pulse (one-cycle destination-domain event strobe).
module cdc_toggle_sync
    import line_buffer_interleave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic RESET,
    input  logic tgl,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Each change of the synchronised level is one event.
    assign pulse = sync_q[SYNC_STAGES-1] ^ last_q;

endmodule

// File: rtl/line_buffer_interleave.sv
// Dual-bank ADC line buffer: N_CH samples written per WR_CLK, one pixel read per RD_EN in raster order.
// Latency: DATA_OUT/DATA_VALID 1 RD_CLK after RD_EN; LINE_READY SYNC_STAGES+1 RD_CLK after line completion.
// Backpressure: none on the write side -- a line with no free bank is dropped and OVERRUN latches; reads paced by RD_EN.
// Ports: RESET async active-high (both domains); WR_CLK/WR_EN/WR_SOL/DATA_IN write side;
// RD_CLK/RD_START/RD_EN/DATA_OUT/DATA_VALID/LINE_READY/RD_BUSY read side; OVERRUN in WR_CLK domain.
// Optional: define LINE_BUF_MIRROR_EN to add MIRROR (sampled at RD_START) for descending readout.
module line_buffer_interleave
    import line_buffer_interleave_pkg::*;
#(
    parameter int DATA_W      = LBI_DATA_W,
    parameter int PIX_PER_ROW = LBI_PIX_PER_ROW,
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   RESET,
    input  logic                   WR_CLK,
    input  logic                   RD_CLK,
    input  logic                   WR_EN,
    input  logic                   WR_SOL,
    input  logic [N_CH*DATA_W-1:0] DATA_IN,
    input  logic                   RD_START,
    input  logic                   RD_EN,
`ifdef LINE_BUF_MIRROR_EN
    input  logic                   MIRROR,
`endif
    output logic [DATA_W-1:0]      DATA_OUT,
    output logic                   DATA_VALID,
    output logic                   LINE_READY,
    output logic                   RD_BUSY,
    output logic                   OVERRUN
);

    localparam int            AW         = addr_w(PIX_PER_ROW);
    localparam int            MW         = addr_w(2 * PIX_PER_ROW);
    localparam int            WR_LAST    = PIX_PER_ROW / N_CH - 1;
    localparam logic [MW-1:0] BANK1_BASE = MW'(PIX_PER_ROW);

    // Bank 0 occupies [0, PIX_PER_ROW), bank 1 [PIX_PER_ROW, 2*PIX_PER_ROW).
    logic [DATA_W-1:0] mem [2*PIX_PER_ROW];

    // ---------------- write domain ----------------
    logic          wr_bank;
    logic [1:0]    wr_busy;    // bank holds a line not yet released by the reader
    logic          free_ptr;   // oldest busy bank: the one the next free event releases
    logic          drop_q;     // current line is being discarded
    logic          full_tgl;
    logic          free_pls;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] eff_cnt;
    logic          line_drop;
    logic [MW-1:0] wr_base;

    always_comb begin
        // WR_SOL restarts the line even when it coincides with a write.
        eff_cnt   = WR_SOL ? '0 : wr_cnt;
        // Drop decision is made once, at the first beat, and held for the line.
        line_drop = (eff_cnt == '0) ? wr_busy[wr_bank] : drop_q;
        wr_base   = (wr_bank ? BANK1_BASE : '0) + MW'(eff_cnt) * MW'(N_CH);
    end

    always_ff @(posedge WR_CLK or posedge RESET) begin
        if (RESET) begin
            wr_bank  <= 1'b0;
            wr_busy  <= 2'b00;
            free_ptr <= 1'b0;
            drop_q   <= 1'b0;
            full_tgl <= 1'b0;
            wr_cnt   <= '0;
            OVERRUN  <= 1'b0;
        end else begin
            // A free event can never target the bank being filled, so this
            // clear and the completion set below touch different bits.
            if (free_pls) begin
                wr_busy[free_ptr] <= 1'b0;
                free_ptr          <= ~free_ptr;
            end
            if (WR_EN) begin
                if (eff_cnt == '0 && wr_busy[wr_bank]) begin
                    OVERRUN <= 1'b1;
                end
                if (eff_cnt == AW'(WR_LAST)) begin
                    wr_cnt <= '0;
                    drop_q <= 1'b0;
                    if (!line_drop) begin
                        wr_busy[wr_bank] <= 1'b1;
                        full_tgl         <= ~full_tgl;
                        wr_bank          <= ~wr_bank;
                    end
                end else begin
                    wr_cnt <= eff_cnt + 1'b1;
                    drop_q <= line_drop;
                end
            end else if (WR_SOL) begin
                wr_cnt <= '0;
                drop_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge WR_CLK) begin
        if (WR_EN && !line_drop) begin
            for (int c = 0; c < N_CH; c++) begin
                mem[wr_base + MW'(c)] <= DATA_IN[c*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------- read domain ----------------
    rd_state_t     rd_state;
    logic          rd_bank;
    logic          free_tgl;
    logic          full_pls;
    logic          claim;
    logic [1:0]    full_cnt;   // full banks not yet claimed by RD_START
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] rd_idx;
    logic [MW-1:0] rd_addr;
`ifdef LINE_BUF_MIRROR_EN
    logic          mirror_q;
`endif

    always_comb begin
`ifdef LINE_BUF_MIRROR_EN
        rd_idx = mirror_q ? (AW'(PIX_PER_ROW - 1) - rd_cnt) : rd_cnt;
`else
        rd_idx = rd_cnt;
`endif
        rd_addr = (rd_bank ? BANK1_BASE : '0) + MW'(rd_idx);
    end

    assign LINE_READY = (full_cnt != 2'd0);
    assign claim      = (rd_state == RD_IDLE) && RD_START && LINE_READY;

    always_ff @(posedge RD_CLK or posedge RESET) begin
        if (RESET) begin
            full_cnt <= 2'd0;
        end else if (full_pls && !claim) begin
            full_cnt <= full_cnt + 2'd1;
        end else if (claim && !full_pls) begin
            full_cnt <= full_cnt - 2'd1;
        end
    end

    always_ff @(posedge RD_CLK or posedge RESET) begin
        if (RESET) begin
            rd_state   <= RD_IDLE;
            rd_bank    <= 1'b0;
            rd_cnt     <= '0;
            free_tgl   <= 1'b0;
            RD_BUSY    <= 1'b0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
`ifdef LINE_BUF_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            DATA_VALID <= 1'b0;
            case (rd_state)
                RD_IDLE: begin
                    if (claim) begin
                        rd_state <= RD_ARMED;
                        rd_cnt   <= '0;
                        RD_BUSY  <= 1'b1;
`ifdef LINE_BUF_MIRROR_EN
                        mirror_q <= MIRROR;
`endif
                    end
                end
                RD_ARMED, RD_READ: begin
                    if (RD_EN) begin
                        DATA_OUT   <= mem[rd_addr];
                        DATA_VALID <= 1'b1;
                        if (rd_cnt == AW'(PIX_PER_ROW - 1)) begin
                            rd_state <= RD_RELEASE;
                        end else begin
                            rd_cnt   <= rd_cnt + 1'b1;
                            rd_state <= RD_READ;
                        end
                    end
                end
                RD_RELEASE: begin
                    free_tgl <= ~free_tgl;
                    rd_bank  <= ~rd_bank;
                    rd_cnt   <= '0;
                    RD_BUSY  <= 1'b0;
                    rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // ---------------- domain crossings ----------------
    cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_full_sync (
        .clk   (RD_CLK),
        .RESET (RESET),
        .tgl   (full_tgl),
        .pulse (full_pls)
    );

    cdc_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_free_sync (
        .clk   (WR_CLK),
        .RESET (RESET),
        .tgl   (free_tgl),
        .pulse (free_pls)
    );

endmodule

// File: tb/tb_line_buffer_interleave.sv
// Directed bench for line_buffer_interleave (N_CH=2, PIX_PER_ROW=8).
// Pixel value for line L, index i is L*16+i, so every line is distinguishable.
module tb_line_buffer_interleave;

    localparam int DW  = 14;
    localparam int PIX = 8;
    localparam int NCH = 2;

    logic              RESET;
    logic              WR_CLK;
    logic              RD_CLK;
    logic              WR_EN;
    logic              WR_SOL;
    logic [NCH*DW-1:0] DATA_IN;
    logic              RD_START;
    logic              RD_EN;
`ifdef LINE_BUF_MIRROR_EN
    logic              MIRROR;
`endif
    logic [DW-1:0]     DATA_OUT;
    logic              DATA_VALID;
    logic              LINE_READY;
    logic              RD_BUSY;
    logic              OVERRUN;

    int wr_half = 5;
    int rd_half = 5;
    int tests   = 0;
    int fails   = 0;

    line_buffer_interleave #(
        .DATA_W      (DW),
        .PIX_PER_ROW (PIX),
        .N_CH        (NCH),
        .SYNC_STAGES (2)
    ) dut (
        .RESET      (RESET),
        .WR_CLK     (WR_CLK),
        .RD_CLK     (RD_CLK),
        .WR_EN      (WR_EN),
        .WR_SOL     (WR_SOL),
        .DATA_IN    (DATA_IN),
        .RD_START   (RD_START),
        .RD_EN      (RD_EN),
`ifdef LINE_BUF_MIRROR_EN
        .MIRROR     (MIRROR),
`endif
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .LINE_READY (LINE_READY),
        .RD_BUSY    (RD_BUSY),
        .OVERRUN    (OVERRUN)
    );

    initial WR_CLK = 1'b0;
    always #(wr_half) WR_CLK = ~WR_CLK;
    initial RD_CLK = 1'b0;
    always #(rd_half) RD_CLK = ~RD_CLK;

    function automatic logic [DW-1:0] pixv(input int line, input int idx);
        return DW'(line * 16 + idx);
    endfunction

    // One write beat: inputs set at the negedge, captured at the next posedge.
    task automatic wr_beat(input bit sol, input logic [DW-1:0] p0, input logic [DW-1:0] p1);
        @(negedge WR_CLK);
        WR_EN   = 1'b1;
        WR_SOL  = sol;
        DATA_IN = {p1, p0};
        @(posedge WR_CLK);
        #1;
        WR_EN  = 1'b0;
        WR_SOL = 1'b0;
    endtask

    task automatic wr_sol_only;
        @(negedge WR_CLK);
        WR_SOL = 1'b1;
        @(posedge WR_CLK);
        #1;
        WR_SOL = 1'b0;
    endtask

    task automatic write_line(input int id);
        for (int k = 0; k < PIX / NCH; k++) wr_beat(1'b0, pixv(id, 2*k), pixv(id, 2*k+1));
    endtask

    task automatic rd_start_pulse;
        @(negedge RD_CLK);
        RD_START = 1'b1;
        @(posedge RD_CLK);
        #1;
        RD_START = 1'b0;
    endtask

    // One read beat; returns the outputs sampled 1 ns after the capturing edge.
    task automatic rd_pixel(output logic [DW-1:0] d, output logic v);
        @(negedge RD_CLK);
        RD_EN = 1'b1;
        @(posedge RD_CLK);
        #1;
        RD_EN = 1'b0;
        d = DATA_OUT;
        v = DATA_VALID;
    endtask

    task automatic wait_line_ready(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge RD_CLK);
            if (LINE_READY === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1; WR_EN = 1'b0; WR_SOL = 1'b0; DATA_IN = '0;
        RD_START = 1'b0; RD_EN = 1'b0;
`ifdef LINE_BUF_MIRROR_EN
        MIRROR = 1'b0;
`endif
        repeat (3) @(posedge WR_CLK);
        #1;
        tests++; if (DATA_OUT !== '0) begin fails++; $display("FAIL reset_data_out: got %0d expected 0", DATA_OUT); end
        tests++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL reset_data_valid: got %b expected 0", DATA_VALID); end
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL reset_line_ready: got %b expected 0", LINE_READY); end
        tests++; if (RD_BUSY !== 1'b0) begin fails++; $display("FAIL reset_rd_busy: got %b expected 0", RD_BUSY); end
        tests++; if (OVERRUN !== 1'b0) begin fails++; $display("FAIL reset_overrun: got %b expected 0", OVERRUN); end
        @(negedge WR_CLK);
        RESET = 1'b0;
        repeat (2) @(posedge RD_CLK);
    endtask

    task automatic test_basic;
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        rd_start_pulse();
        @(negedge RD_CLK);
        tests++; if (RD_BUSY !== 1'b0) begin fails++; $display("FAIL start_ignored_busy: got %b expected 0", RD_BUSY); end
        write_line(0);
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL ready_not_instant: got %b expected 0", LINE_READY); end
        wait_line_ready(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_line_ready: got %b expected 1", ok); end
        rd_start_pulse();
        tests++; if (RD_BUSY !== 1'b1) begin fails++; $display("FAIL busy_armed: got %b expected 1", RD_BUSY); end
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(0, i)) begin
                fails++; $display("FAIL basic_pix[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(0, i));
            end
        end
        @(posedge RD_CLK);
        #1;
        tests++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL valid_drops: got %b expected 0", DATA_VALID); end
        tests++; if (DATA_OUT !== pixv(0, 7)) begin fails++; $display("FAIL data_holds: got %0d expected %0d", DATA_OUT, pixv(0, 7)); end
        repeat (2) @(posedge RD_CLK);
        #1;
        tests++; if (RD_BUSY !== 1'b0) begin fails++; $display("FAIL busy_after_line: got %b expected 0", RD_BUSY); end
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL ready_after_line: got %b expected 0", LINE_READY); end
    endtask

    task automatic test_overrun;
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        repeat (10) @(posedge WR_CLK);
        write_line(1);
        write_line(2);
        repeat (3) @(posedge WR_CLK);
        #1;
        tests++; if (OVERRUN !== 1'b0) begin fails++; $display("FAIL overrun_two_lines: got %b expected 0", OVERRUN); end
        write_line(3);
        tests++; if (OVERRUN !== 1'b1) begin fails++; $display("FAIL overrun_third_line: got %b expected 1", OVERRUN); end
        wait_line_ready(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL overrun_ready: got %b expected 1", ok); end
        rd_start_pulse();
        for (int i = 0; i < PIX; i++) begin
            if (i == 3) RD_START = 1'b1;   // must be ignored mid-line
            rd_pixel(d, v);
            RD_START = 1'b0;
            tests++;
            if (v !== 1'b1 || d !== pixv(1, i)) begin
                fails++; $display("FAIL overrun_line1[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(1, i));
            end
        end
        repeat (2) @(posedge RD_CLK);
        #1;
        tests++; if (LINE_READY !== 1'b1) begin fails++; $display("FAIL second_line_waiting: got %b expected 1", LINE_READY); end
        rd_start_pulse();
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(2, i)) begin
                fails++; $display("FAIL overrun_line2[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(2, i));
            end
        end
        repeat (4) @(posedge RD_CLK);
        #1;
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL dropped_line_absent: got %b expected 0", LINE_READY); end
        tests++; if (OVERRUN !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %b expected 1", OVERRUN); end
    endtask

    task automatic test_sol;
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        repeat (10) @(posedge WR_CLK);
        wr_beat(1'b0, pixv(4, 0), pixv(4, 1));
        wr_beat(1'b0, pixv(4, 2), pixv(4, 3));
        wr_sol_only();
        repeat (8) @(posedge RD_CLK);
        #1;
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL sol_partial_discarded: got %b expected 0", LINE_READY); end
        write_line(5);
        // Partial line, then a new line whose first beat carries WR_SOL.
        wr_beat(1'b0, pixv(6, 0), pixv(6, 1));
        for (int k = 0; k < PIX / NCH; k++) wr_beat(k == 0, pixv(7, 2*k), pixv(7, 2*k+1));
        wait_line_ready(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL sol_ready: got %b expected 1", ok); end
        rd_start_pulse();
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(5, i)) begin
                fails++; $display("FAIL sol_line[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(5, i));
            end
        end
        wait_line_ready(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL sol_en_ready: got %b expected 1", ok); end
        rd_start_pulse();
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(7, i)) begin
                fails++; $display("FAIL sol_en_line[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(7, i));
            end
        end
        repeat (4) @(posedge RD_CLK);
    endtask

    task automatic test_reset_mid_read;
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        repeat (10) @(posedge WR_CLK);
        write_line(9);
        write_line(10);
        wait_line_ready(ok);
        rd_start_pulse();
        for (int i = 0; i < 3; i++) rd_pixel(d, v);
        tests++; if (d !== pixv(9, 2)) begin fails++; $display("FAIL pre_reset_pix: got %0d expected %0d", d, pixv(9, 2)); end
        RESET = 1'b1;
        #1;
        tests++; if (DATA_OUT !== '0) begin fails++; $display("FAIL midreset_data_out: got %0d expected 0", DATA_OUT); end
        tests++; if (DATA_VALID !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b expected 0", DATA_VALID); end
        tests++; if (LINE_READY !== 1'b0) begin fails++; $display("FAIL midreset_ready: got %b expected 0", LINE_READY); end
        tests++; if (RD_BUSY !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", RD_BUSY); end
        tests++; if (OVERRUN !== 1'b0) begin fails++; $display("FAIL midreset_overrun: got %b expected 0", OVERRUN); end
        repeat (2) @(posedge WR_CLK);
        @(negedge WR_CLK);
        RESET = 1'b0;
        write_line(11);
        wait_line_ready(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL postreset_ready: got %b expected 1", ok); end
        rd_start_pulse();
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(11, i)) begin
                fails++; $display("FAIL postreset_line[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(11, i));
            end
        end
        repeat (4) @(posedge RD_CLK);
    endtask

    // Writer paces lines with 'gap' idle WR_CLK cycles; reader starts on LINE_READY.
    task automatic test_stream(input int wr_h, input int rd_h, input int first_id, input int n, input int gap);
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        bit            abort;
        wr_half = wr_h;
        rd_half = rd_h;
        abort   = 1'b0;
        repeat (4) @(posedge WR_CLK);
        repeat (4) @(posedge RD_CLK);
        fork
            begin : writer
                for (int l = 0; l < n; l++) begin
                    write_line(first_id + l);
                    repeat (gap) @(posedge WR_CLK);
                end
            end
            begin : reader
                for (int l = 0; l < n && !abort; l++) begin
                    wait_line_ready(ok);
                    tests++;
                    if (ok !== 1'b1) begin
                        fails++; abort = 1'b1;
                        $display("FAIL stream_ready_timeout: line %0d got ready=%b expected 1", first_id + l, ok);
                    end else begin
                        rd_start_pulse();
                        for (int i = 0; i < PIX; i++) begin
                            rd_pixel(d, v);
                            tests++;
                            if (v !== 1'b1 || d !== pixv(first_id + l, i)) begin
                                fails++;
                                $display("FAIL stream_pix line %0d [%0d]: got data=%0d valid=%b expected data=%0d valid=1",
                                         first_id + l, i, d, v, pixv(first_id + l, i));
                            end
                        end
                    end
                end
            end
        join
        repeat (4) @(posedge WR_CLK);
        #1;
        tests++; if (OVERRUN !== 1'b0) begin fails++; $display("FAIL stream_overrun %0d:%0d: got %b expected 0", wr_h, rd_h, OVERRUN); end
    endtask

`ifdef LINE_BUF_MIRROR_EN
    task automatic test_mirror;
        logic [DW-1:0] d;
        logic          v;
        bit            ok;
        wr_half = 5;
        rd_half = 5;
        repeat (10) @(posedge WR_CLK);
        write_line(30);
        write_line(31);
        wait_line_ready(ok);
        MIRROR = 1'b1;
        rd_start_pulse();
        MIRROR = 1'b0;   // only the value at RD_START matters
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(30, PIX - 1 - i)) begin
                fails++; $display("FAIL mirror_on[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(30, PIX - 1 - i));
            end
        end
        wait_line_ready(ok);
        MIRROR = 1'b0;
        rd_start_pulse();
        MIRROR = 1'b1;
        for (int i = 0; i < PIX; i++) begin
            rd_pixel(d, v);
            tests++;
            if (v !== 1'b1 || d !== pixv(31, i)) begin
                fails++; $display("FAIL mirror_off[%0d]: got data=%0d valid=%b expected data=%0d valid=1", i, d, v, pixv(31, i));
            end
        end
        MIRROR = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_sol();
        test_reset_mid_read();
        test_stream(5, 15, 100, 50, 80);
        test_stream(15, 5, 150, 50, 15);
`ifdef LINE_BUF_MIRROR_EN
        test_mirror();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
